// File: rtl/wb_trng_ctrl.sv
// wb_trng_ctrl: Wishbone slave that assembles TRNG bytes into 32-bit words and queues them in a FIFO.
// Latency: one registered response per access; the first word lands 4*(SETTLE+1)+2 cycles after enable rises.
// Backpressure: sampling pauses in IDLE while the FIFO is full; DATA reads on an empty FIFO answer with err.
// Optional repetition-count health test is compiled in only when WB_TRNG_CTRL_HEALTH_EN is defined.

// wb_trng_fifo: power-of-two circular word queue with level count and synchronous flush.
// Latency: a push is visible at the head on the next cycle; a pop takes effect at the same edge.
// Backpressure: pushes while full and pops while empty are dropped; flush overrides both.
module wb_trng_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_dat,
  output logic [$clog2(DEPTH):0] level,
  output logic                   empty,
  output logic                   full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign empty    = (level_q == '0);
  assign full     = (level_q == (AW+1)'(DEPTH));
  assign level    = level_q;
  assign head_dat = mem_q[rd_ptr_q];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  // Next pointers, level and storage; pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + (AW+1)'(1);
        2'b01:   level_d = level_q - (AW+1)'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // Word storage carries no reset; validity is defined by the pointers and level alone.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Pointer and level registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end
endmodule

module wb_trng_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int SETTLE     = 2,
  parameter int REP_LIMIT  = 8
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic [2:0]  wb_cti_i,
  input  logic [1:0]  wb_bte_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        wb_rty_o,
  output logic        trng_en,
  input  logic [7:0]  trng_r,
  output logic        irq
);
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_PUSH    = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  settle_cnt_q, settle_cnt_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] word_q, word_d;
  logic        ctrl_en_q, ctrl_en_d, ctrl_irq_en_q, ctrl_irq_en_d;
  logic        ack_q, ack_d, err_q, err_d;
  logic [31:0] dat_o_q, dat_o_d;

  logic        req, clear_fail, capture, health_fail, health_trip;
  logic        fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [31:0] fifo_head;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;
  logic [3:0]  level4;
  logic        unused_bus;

  wb_trng_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
    .clk      (wb_clk),
    .rst      (wb_rst),
    .flush    (health_trip),
    .push     (fifo_push),
    .push_dat (word_q),
    .pop      (fifo_pop),
    .head_dat (fifo_head),
    .level    (fifo_level),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  assign req        = wb_cyc_i && wb_stb_i && !ack_q && !err_q;
  assign level4     = 4'(fifo_level);
  assign capture    = (state_q == ST_CAPTURE) && ctrl_en_q;
  assign trng_en    = (state_q == ST_SETTLE) || (state_q == ST_CAPTURE);
  assign irq        = ctrl_irq_en_q && !fifo_empty;
  assign wb_ack_o   = ack_q;
  assign wb_err_o   = err_q;
  assign wb_dat_o   = dat_o_q;
  assign wb_rty_o   = 1'b0;
  assign unused_bus = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:3], wb_cti_i, wb_bte_i};

  // Register decode: one registered response per accepted cycle; read data is zero unless acked.
  always_comb begin
    ack_d         = 1'b0;
    err_d         = 1'b0;
    dat_o_d       = 32'h0;
    fifo_pop      = 1'b0;
    clear_fail    = 1'b0;
    ctrl_en_d     = ctrl_en_q;
    ctrl_irq_en_d = ctrl_irq_en_q;
    if (req) begin
      case (wb_adr_i[3:2])
        2'd0: begin
          if (wb_we_i) begin
            ack_d = 1'b1;
          end else if (fifo_empty) begin
            err_d = 1'b1;
          end else begin
            ack_d    = 1'b1;
            dat_o_d  = fifo_head;
            fifo_pop = 1'b1;
          end
        end
        2'd1: begin
          ack_d = 1'b1;
          if (!wb_we_i) dat_o_d = {24'h0, level4, 1'b0, health_fail, fifo_full, fifo_empty};
        end
        2'd2: begin
          ack_d = 1'b1;
          if (wb_we_i) begin
            ctrl_en_d     = wb_dat_i[0];
            ctrl_irq_en_d = wb_dat_i[1];
            clear_fail    = wb_dat_i[2];
          end else begin
            dat_o_d = {30'h0, ctrl_irq_en_q, ctrl_en_q};
          end
        end
        default: ack_d = 1'b1;
      endcase
    end
  end

`ifdef WB_TRNG_CTRL_HEALTH_EN
  logic [7:0] rep_cnt_q, rep_cnt_d, last_byte_q, last_byte_d;
  logic       health_fail_q, health_fail_d;

  // Count runs of identical captured bytes; a run of REP_LIMIT latches the failure and flushes.
  always_comb begin
    rep_cnt_d     = rep_cnt_q;
    last_byte_d   = last_byte_q;
    health_fail_d = health_fail_q;
    health_trip   = 1'b0;
    if (capture) begin
      last_byte_d = trng_r;
      if ((rep_cnt_q != 8'd0) && (trng_r == last_byte_q)) rep_cnt_d = rep_cnt_q + 8'd1;
      else rep_cnt_d = 8'd1;
      if (rep_cnt_d == 8'(REP_LIMIT)) begin
        health_trip   = 1'b1;
        health_fail_d = 1'b1;
      end
    end
    if (clear_fail) begin
      health_fail_d = 1'b0;
      rep_cnt_d     = 8'd0;
    end
  end

  // Health test state registers.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      rep_cnt_q     <= 8'd0;
      last_byte_q   <= 8'd0;
      health_fail_q <= 1'b0;
    end else begin
      rep_cnt_q     <= rep_cnt_d;
      last_byte_q   <= last_byte_d;
      health_fail_q <= health_fail_d;
    end
  end

  assign health_fail = health_fail_q;
`else
  logic unused_health;
  assign health_fail   = 1'b0;
  assign health_trip   = 1'b0;
  assign unused_health = clear_fail ^ (REP_LIMIT == 0);
`endif

  // Sampling sequencer: settle, capture one byte lane, repeat four times, then push the word.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    word_d       = word_q;
    fifo_push    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ctrl_en_q && !fifo_full && !health_fail) begin
          state_d      = ST_SETTLE;
          settle_cnt_d = 8'd0;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt_q == 8'(SETTLE - 1)) state_d = ST_CAPTURE;
        else settle_cnt_d = settle_cnt_q + 8'd1;
      end
      ST_CAPTURE: begin
        word_d[{byte_cnt_q, 3'b000} +: 8] = trng_r;
        byte_cnt_d   = byte_cnt_q + 2'd1;
        settle_cnt_d = 8'd0;
        state_d      = (byte_cnt_q == 2'd3) ? ST_PUSH : ST_SETTLE;
      end
      ST_PUSH: begin
        fifo_push = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Disabling or a health trip abandons any partial word; a completed word in PUSH still lands.
    if (!ctrl_en_q || health_trip) begin
      state_d    = ST_IDLE;
      byte_cnt_d = 2'd0;
    end
  end

  // Sequencer, control and bus response registers.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_q       <= ST_IDLE;
      settle_cnt_q  <= 8'd0;
      byte_cnt_q    <= 2'd0;
      word_q        <= 32'h0;
      ctrl_en_q     <= 1'b0;
      ctrl_irq_en_q <= 1'b0;
      ack_q         <= 1'b0;
      err_q         <= 1'b0;
      dat_o_q       <= 32'h0;
    end else begin
      state_q       <= state_d;
      settle_cnt_q  <= settle_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      word_q        <= word_d;
      ctrl_en_q     <= ctrl_en_d;
      ctrl_irq_en_q <= ctrl_irq_en_d;
      ack_q         <= ack_d;
      err_q         <= err_d;
      dat_o_q       <= dat_o_d;
    end
  end
endmodule

// File: tb/tb_wb_trng_ctrl.sv
// tb_wb_trng_ctrl: directed bench for wb_trng_ctrl with a byte source that steps once per capture.
// Latency: every access takes a request cycle plus one response cycle.
// Backpressure: DATA reads on an empty FIFO are expected to return err.
`timescale 1ns/1ps
module tb_wb_trng_ctrl;
  localparam int SETTLE_P = 2;

  logic        wb_clk = 1'b0;
  logic        wb_rst;
  logic [31:0] wb_adr_i, wb_dat_i;
  logic        wb_we_i, wb_cyc_i, wb_stb_i;
  logic [2:0]  wb_cti_i;
  logic [1:0]  wb_bte_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o, wb_err_o, wb_rty_o, trng_en, irq;
  logic [7:0]  trng_r;

  int checks   = 0;
  int failures = 0;

  // Byte source: trng_base (+ number of captures seen when auto_inc) since the last set_trng.
  logic [7:0] trng_base   = 8'h00;
  logic       auto_inc    = 1'b0;
  int         epoch       = 0;
  logic [7:0] cap_cnt     = 8'h00;
  int         seen_epoch  = 0;
  int         idx         = 0;
  bit         cap_pending = 1'b0;

  assign trng_r = trng_base + (auto_inc ? cap_cnt : 8'h00);

  wb_trng_ctrl #(.FIFO_DEPTH(4), .SETTLE(SETTLE_P), .REP_LIMIT(8)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
    .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_cti_i(wb_cti_i),
    .wb_bte_i(wb_bte_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
    .wb_rty_o(wb_rty_o), .trng_en(trng_en), .trng_r(trng_r), .irq(irq)
  );

  always #5 wb_clk = ~wb_clk;

  // A capture happens on the last of every SETTLE+1 consecutive enabled cycles; step the byte after it.
  initial begin
    forever begin
      @(posedge wb_clk); #2;
      if (epoch != seen_epoch) begin
        seen_epoch = epoch;
        cap_cnt    = 8'h00;
      end else if (cap_pending) begin
        cap_cnt = cap_cnt + 8'h01;
      end
      cap_pending = 1'b0;
      if (trng_en) begin
        if (idx == SETTLE_P) begin
          cap_pending = 1'b1;
          idx         = 0;
        end else begin
          idx++;
        end
      end else begin
        idx = 0;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge wb_clk);
    #1;
  endtask

  task automatic do_reset();
    wb_rst = 1'b1;
    idle(2);
    wb_rst = 1'b0;
  endtask

  task automatic set_trng(input logic [7:0] base, input logic inc);
    trng_base = base;
    auto_inc  = inc;
    epoch++;
  endtask

  task automatic wb_read(input logic [31:0] adr, output logic [31:0] dat, output logic ack, output logic err);
    wb_adr_i = adr; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(posedge wb_clk); #1;
    dat = wb_dat_o; ack = wb_ack_o; err = wb_err_o;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(posedge wb_clk); #1;
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, output logic ack);
    wb_adr_i = adr; wb_dat_i = dat; wb_we_i = 1'b1; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(posedge wb_clk); #1;
    ack = wb_ack_o;
    wb_we_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(posedge wb_clk); #1;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic a, e;
    wb_rst = 1'b1; wb_adr_i = 32'h4; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    idle(2);
    checks++; if (wb_ack_o !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", wb_ack_o); end
    checks++; if (wb_err_o !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", wb_err_o); end
    checks++; if (wb_dat_o !== 32'h0) begin failures++; $display("FAIL reset_dat got=%h exp=0", wb_dat_o); end
    checks++; if (trng_en !== 1'b0) begin failures++; $display("FAIL reset_trng_en got=%b exp=0", trng_en); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
    checks++; if (wb_rty_o !== 1'b0) begin failures++; $display("FAIL reset_rty got=%b exp=0", wb_rty_o); end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_rst = 1'b0;
    idle(1);
    checks++; if (wb_ack_o !== 1'b0) begin failures++; $display("FAIL reset_abort_ack got=%b exp=0", wb_ack_o); end
    wb_read(32'h4, d, a, e);
    checks++; if (a !== 1'b1 || d !== 32'h1) begin failures++; $display("FAIL reset_status got=%h ack=%b exp=00000001 ack=1", d, a); end
    wb_read(32'h8, d, a, e);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL reset_ctrl got=%h exp=00000000", d); end
  endtask

  task automatic test_empty_err();
    logic [31:0] d; logic a, e;
    do_reset();
    wb_adr_i = 32'h0; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    idle(1);
    checks++; if (wb_err_o !== 1'b1 || wb_ack_o !== 1'b0) begin failures++; $display("FAIL empty_err got err=%b ack=%b exp err=1 ack=0", wb_err_o, wb_ack_o); end
    checks++; if (wb_dat_o !== 32'h0) begin failures++; $display("FAIL empty_dat got=%h exp=0", wb_dat_o); end
    idle(1);
    checks++; if (wb_err_o !== 1'b0 || wb_ack_o !== 1'b0) begin failures++; $display("FAIL empty_single_resp got err=%b ack=%b exp 0 0", wb_err_o, wb_ack_o); end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    idle(1);
    wb_read(32'h4, d, a, e);
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL empty_status got=%h exp=00000001", d); end
    wb_read(32'hC, d, a, e);
    checks++; if (a !== 1'b1 || d !== 32'h0) begin failures++; $display("FAIL addr3_read got=%h ack=%b exp=0 ack=1", d, a); end
    wb_write(32'h4, 32'hFFFF_FFFF, a);
    checks++; if (a !== 1'b1) begin failures++; $display("FAIL status_write_ack got=%b exp=1", a); end
    wb_read(32'h4, d, a, e);
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL status_ro got=%h exp=00000001", d); end
    wb_write(32'h8, 32'h6, a);
    wb_read(32'h8, d, a, e);
    checks++; if (d !== 32'h2) begin failures++; $display("FAIL ctrl_readback got=%h exp=00000002", d); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_empty got=%b exp=0", irq); end
  endtask

  task automatic test_first_word();
    logic [31:0] d; logic a, e;
    do_reset();
    set_trng(8'h10, 1'b1);
    wb_write(32'h8, 32'h1, a);
    idle(12);
    wb_read(32'h0, d, a, e);
    checks++; if (e !== 1'b1 || a !== 1'b0) begin failures++; $display("FAIL first_word_early got err=%b ack=%b exp err=1 ack=0", e, a); end
    wb_read(32'h0, d, a, e);
    checks++; if (a !== 1'b1 || e !== 1'b0) begin failures++; $display("FAIL first_word_ack got ack=%b err=%b exp ack=1 err=0", a, e); end
    checks++; if (d !== 32'h1312_1110) begin failures++; $display("FAIL first_word_data got=%h exp=13121110", d); end
  endtask

  task automatic test_full();
    logic [31:0] d; logic a, e;
    do_reset();
    set_trng(8'h10, 1'b1);
    wb_write(32'h8, 32'h3, a);
    idle(60);
    checks++; if (trng_en !== 1'b0) begin failures++; $display("FAIL full_trng_en got=%b exp=0", trng_en); end
    wb_read(32'h4, d, a, e);
    checks++; if (d !== 32'h42) begin failures++; $display("FAIL full_status got=%h exp=00000042", d); end
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL full_irq got=%b exp=1", irq); end
    idle(3);
    checks++; if (trng_en !== 1'b0) begin failures++; $display("FAIL full_trng_en_hold got=%b exp=0", trng_en); end
    wb_read(32'h0, d, a, e);
    checks++; if (d !== 32'h1312_1110) begin failures++; $display("FAIL full_pop_data got=%h exp=13121110", d); end
    checks++; if (trng_en !== 1'b1) begin failures++; $display("FAIL full_refill got=%b exp=1", trng_en); end
    wb_read(32'h4, d, a, e);
    checks++; if (d !== 32'h30) begin failures++; $display("FAIL full_after_pop_status got=%h exp=00000030", d); end
  endtask

  task automatic test_abort();
    logic [31:0] d; logic a, e;
    do_reset();
    set_trng(8'h10, 1'b1);
    wb_write(32'h8, 32'h1, a);
    idle(6);
    wb_write(32'h8, 32'h0, a);
    checks++; if (trng_en !== 1'b0) begin failures++; $display("FAIL abort_trng_en got=%b exp=0", trng_en); end
    wb_read(32'h4, d, a, e);
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL abort_status got=%h exp=00000001", d); end
    set_trng(8'h40, 1'b1);
    wb_write(32'h8, 32'h1, a);
    idle(14);
    wb_read(32'h0, d, a, e);
    checks++; if (a !== 1'b1 || d !== 32'h4342_4140) begin failures++; $display("FAIL abort_new_word got=%h ack=%b exp=43424140 ack=1", d, a); end
  endtask

  task automatic test_push_pop();
    logic [31:0] d; logic a, e;
    do_reset();
    set_trng(8'h10, 1'b1);
    wb_write(32'h8, 32'h3, a);
    idle(40);
    wb_read(32'h0, d, a, e);
    checks++; if (d !== 32'h1312_1110) begin failures++; $display("FAIL pushpop_first got=%h exp=13121110", d); end
    wb_read(32'h4, d, a, e);
    checks++; if (d !== 32'h20) begin failures++; $display("FAIL pushpop_level got=%h exp=00000020", d); end
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL pushpop_irq got=%b exp=1", irq); end
    wb_read(32'h0, d, a, e);
    checks++; if (d !== 32'h1716_1514) begin failures++; $display("FAIL pushpop_second got=%h exp=17161514", d); end
    wb_read(32'h0, d, a, e);
    checks++; if (d !== 32'h1B1A_1918) begin failures++; $display("FAIL pushpop_third got=%h exp=1b1a1918", d); end
    wb_read(32'h4, d, a, e);
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL pushpop_drained got=%h exp=00000001", d); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL pushpop_irq_clear got=%b exp=0", irq); end
  endtask

`ifdef WB_TRNG_CTRL_HEALTH_EN
  task automatic test_health();
    logic [31:0] d; logic a, e;
    do_reset();
    set_trng(8'hAA, 1'b0);
    wb_write(32'h8, 32'h1, a);
    idle(28);
    wb_read(32'h4, d, a, e);
    checks++; if (d !== 32'h05) begin failures++; $display("FAIL health_status got=%h exp=00000005", d); end
    checks++; if (trng_en !== 1'b0) begin failures++; $display("FAIL health_hold got=%b exp=0", trng_en); end
    set_trng(8'h50, 1'b1);
    wb_write(32'h8, 32'h5, a);
    wb_read(32'h8, d, a, e);
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL health_ctrl got=%h exp=00000001", d); end
    idle(12);
    wb_read(32'h0, d, a, e);
    checks++; if (a !== 1'b1 || d !== 32'h5352_5150) begin failures++; $display("FAIL health_resume got=%h ack=%b exp=53525150 ack=1", d, a); end
  endtask
`endif

  initial begin
    wb_rst = 1'b1; wb_adr_i = 32'h0; wb_dat_i = 32'h0; wb_we_i = 1'b0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_cti_i = 3'h0; wb_bte_i = 2'h0;
    test_reset();
    test_empty_err();
    test_first_word();
    test_full();
    test_abort();
    test_push_pop();
`ifdef WB_TRNG_CTRL_HEALTH_EN
    test_health();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wb_trng_ctrl.md
WB_TRNG_CTRL -- requirements
Module: wb_trng_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4: entropy FIFO depth in 32-bit words; power of two, 2..16.
REQ-002 SHALL have parameter SETTLE, default 2: cycles trng_en is held high before each byte capture; range 1..255.
REQ-003 SHALL have parameter REP_LIMIT, default 8: identical consecutive bytes that trip the health test; range 2..255.
REQ-004 SHALL have port wb_clk, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port wb_rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have ports wb_adr_i in 32, wb_dat_i in 32, wb_we_i in 1, wb_cyc_i in 1, wb_stb_i in 1, wb_cti_i in 3, wb_bte_i in 2: Wishbone slave inputs; cti/bte ignored.
REQ-007 SHALL have ports wb_dat_o out 32, wb_ack_o out 1, wb_err_o out 1, wb_rty_o out 1: Wishbone slave outputs; wb_rty_o tied 0.
REQ-008 SHALL have port trng_en, output, 1: enable to the TRNG core.
REQ-009 SHALL have port trng_r, input, 8: sample byte from the TRNG core.
REQ-010 SHALL have port irq, output, 1: high while the FIFO is non-empty and CTRL.irq_en is 1.

Function
REQ-011 SHALL decode wb_adr_i[3:2]: 0 DATA (RO), 1 STATUS (RO), 2 CTRL (RW); 3 reads 0, writes ignored.
REQ-012 SHALL define STATUS as: [0] empty, [1] full, [2] health_fail, [7:4] FIFO level, other bits 0.
REQ-013 SHALL define CTRL as: [0] enable, [1] irq_en, [2] clear_fail (write-1 pulse, reads 0), other bits 0.
REQ-014 SHALL respond to every cycle where cyc&stb is high and wb_ack_o/wb_err_o are low with exactly one registered response cycle: ack or err, one cycle later; no response on the following cycle.
REQ-015 SHALL, on a DATA read with the FIFO non-empty, return the head word with ack and pop it in the same cycle.
REQ-016 SHALL, on a DATA read with the FIFO empty, assert wb_err_o instead of ack, drive wb_dat_o = 0, and not change the FIFO.
REQ-017 SHALL drive wb_dat_o = 0 in any cycle without ack.
REQ-018 SHALL sequence the core with an FSM of states IDLE, SETTLE, CAPTURE, PUSH.
REQ-019 SHALL move IDLE->SETTLE when enable=1, FIFO not full and health_fail=0; otherwise it stays in IDLE.
REQ-020 SHALL hold trng_en=1 in SETTLE and CAPTURE, and trng_en=0 in IDLE and PUSH.
REQ-021 SHALL remain in SETTLE for exactly SETTLE cycles, then enter CAPTURE.
REQ-022 SHALL, in CAPTURE, latch trng_r into byte lane byte_cnt (lane 0 = bits[7:0]) and increment a 2-bit byte_cnt.
REQ-023 SHALL go CAPTURE->SETTLE when byte_cnt was <3, and CAPTURE->PUSH when byte_cnt was 3.
REQ-024 SHALL, in PUSH, write the assembled word to the FIFO tail, then enter IDLE; the first word is therefore visible 4*(SETTLE+1)+2 cycles after enable rises.
REQ-025 SHALL, when a push and a pop occur in the same cycle, perform both and leave the level unchanged.
REQ-026 SHALL wrap the FIFO pointers modulo FIFO_DEPTH and hold level in a $clog2(FIFO_DEPTH)+1-bit count.
REQ-027 SHALL, when enable is cleared in any state, discard the partial word, zero byte_cnt and return to IDLE next cycle; FIFO contents are kept.

Reset
REQ-028 SHALL, while wb_rst is high on a clock edge, enter IDLE and clear FIFO pointers/level, byte_cnt, CTRL, health_fail and the repetition counter.
REQ-029 SHALL drive, after reset, wb_ack_o=0, wb_err_o=0, wb_dat_o=0, trng_en=0 and irq=0.
REQ-030 SHALL treat reset asserted mid-transaction as aborting it: no response is issued for that cycle.

Configuration
REQ-031 SHALL compile the health test only when macro WB_TRNG_CTRL_HEALTH_EN is defined.
REQ-032 SHALL, with the macro defined, count consecutive identical captured bytes; on reaching REP_LIMIT: set health_fail, flush the FIFO, discard the partial word and hold the FSM in IDLE.
REQ-033 SHALL, with the macro defined, have CTRL.clear_fail clear health_fail and the repetition counter.
REQ-034 SHALL, without the macro, contain no repetition counter and read STATUS[2] as 0.

Verification
REQ-035 SHALL test: trng_r increments per capture from 0x10, SETTLE=2, enable=1 -> first DATA read acks with 0x13121110 after 14 cycles.
REQ-036 SHALL test: DATA read with empty FIFO -> wb_err_o for one cycle, wb_dat_o=0, STATUS.empty stays 1.
REQ-037 SHALL test: FIFO filled to 4 words -> STATUS=0x42, trng_en stays 0; one read -> refill starts within 1 cycle.
REQ-038 SHALL test: enable cleared after 2 captures, then re-set -> the next word contains only the new 4 bytes.
REQ-039 SHALL test, with the macro defined: trng_r held at 0xAA for 8 captures -> STATUS=0x05, FIFO empty; clear_fail write -> filling resumes.
REQ-040 SHALL test: push and pop in the same cycle at level 2 -> level stays 2 and word order is preserved.
